// File: rtl/oisc_instr_fetch.sv
// rtl/oisc_instr_fetch.sv - OISC instruction fetch/prefetch stage with credit-checked FIFO
// Optional InstrPC head-address output is enabled by OISC_FETCH_PC_OUT_EN.
module oisc_instr_fetch #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Redirect,
  input  logic [ADDR_WIDTH-1:0]  RedirectAddr,
  output logic                   MemReqValid,
  input  logic                   MemReqReady,
  output logic [ADDR_WIDTH-1:0]  MemReqAddr,
  input  logic                   MemRspValid,
  input  logic [INSTR_WIDTH-1:0] MemRspData,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  output logic [INSTR_WIDTH-1:0] InstrData
`ifdef OISC_FETCH_PC_OUT_EN
  ,
  output logic [ADDR_WIDTH-1:0]  InstrPC
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_U = (CW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          discard_q, discard_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0] data_q [DEPTH];
  logic [INSTR_WIDTH-1:0] data_d [DEPTH];
`ifdef OISC_FETCH_PC_OUT_EN
  logic [ADDR_WIDTH-1:0]  apc_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  apc_d [DEPTH];
  logic [ADDR_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
`endif

  logic       flush;
  logic       req_fire;
  logic       push;
  logic       pop;
  logic [CW:0] used;

  always_comb begin
    flush       = Stop | Redirect | Start;
    used        = {1'b0, count_q} + {1'b0, inflight_q};
    // Credit check uses registered occupancy so every accepted request owns a FIFO slot.
    MemReqValid = (state_q == RUN) && (used < DEPTH_U) && !flush && (discard_q == '0);
    MemReqAddr  = pc_q;
    InstrValid  = (count_q != '0);
    InstrData   = data_q[rd_ptr_q];
    req_fire    = MemReqValid & MemReqReady;
    pop         = InstrValid & InstrReady;
    push        = MemRspValid & (discard_q == '0) & !flush;

    state_d = state_q;
    if (Stop) begin
      state_d = IDLE;
    end else if (Start) begin
      state_d = RUN;
    end

    pc_d = pc_q;
    if (Redirect && !Stop) begin
      pc_d = RedirectAddr;
    end else if (Start && !Stop) begin
      pc_d = BOOT_ADDR;
    end else if (req_fire) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end

    inflight_d = inflight_q + CW'(req_fire) - CW'(MemRspValid);

    discard_d = discard_q - CW'(MemRspValid && (discard_q != '0));
    if (flush) begin
      discard_d = inflight_d;
    end

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = MemRspData;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

`ifdef OISC_FETCH_PC_OUT_EN
    // Responses return in order, so the tail address simply follows the flush target.
    InstrPC  = apc_q[rd_ptr_q];
    apc_d    = apc_q;
    rsp_pc_d = rsp_pc_q;
    if (Redirect && !Stop) begin
      rsp_pc_d = RedirectAddr;
    end else if (Start && !Stop) begin
      rsp_pc_d = BOOT_ADDR;
    end else if (push) begin
      apc_d[wr_ptr_q] = rsp_pc_q;
      rsp_pc_d        = rsp_pc_q + ADDR_WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      data_q     <= '{default: '0};
`ifdef OISC_FETCH_PC_OUT_EN
      apc_q      <= '{default: '0};
      rsp_pc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      data_q     <= data_d;
`ifdef OISC_FETCH_PC_OUT_EN
      apc_q      <= apc_d;
      rsp_pc_q   <= rsp_pc_d;
`endif
    end
  end

endmodule
